// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - Avalon-MM SDRAM fill-and-verify pattern tester with pipelined reads
//
// Writes TEST_WORDS words starting at BASE_ADDR with the selected pattern, then reads them back
// (up to MAX_OUTSTANDING reads in flight) and compares each response against an independent
// expected-pattern generator.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, mode                   1-cycle start pulse (accepted when idle), pattern select
//   busy, done, pass              status: test running / last test finished / finished clean
//   err_count                     saturating count of mismatching words
//   first_err_addr/_data          address and received data of the first mismatch
//   avalon_sdram_*                Avalon-MM master (active-low read_n/write_n/byteenable_n)
module sdram_pattern_tester #(
    parameter int          DATA_W          = 16,
    parameter int          ADDR_W          = 24,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned TEST_WORDS      = 1024,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          ERR_CNT_W       = 16,
    parameter logic [31:0] SEED            = 32'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [ADDR_W-1:0]     avalon_sdram_address,
    output logic [DATA_W/8-1:0]   avalon_sdram_byteenable_n,
    output logic                  avalon_sdram_chipselect,
    output logic [DATA_W-1:0]     avalon_sdram_writedata,
    output logic                  avalon_sdram_read_n,
    output logic                  avalon_sdram_write_n,
    input  logic [DATA_W-1:0]     avalon_sdram_readdata,
    input  logic                  avalon_sdram_readdatavalid,
    input  logic                  avalon_sdram_waitrequest
);

    // One extra bit so the read index can step past the last word without wrapping.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_WORDS - 1);
    localparam logic [3:0]       MAX_O    = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           mode_q;
    logic [IDX_W-1:0]     iss_idx, chk_idx;
    logic [31:0]          iss_lfsr, chk_lfsr;
    logic [3:0]           outstanding, out_nxt;
    logic                 done_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic [ADDR_W-1:0]    fe_addr_q;
    logic [DATA_W-1:0]    fe_data_q;

    logic                 wr_req, rd_req, wr_acc, rd_acc, rsp_valid, last_iss, start_ok, mismatch;
    logic [DATA_W-1:0]    expected;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        // Fibonacci, taps 32,22,2,1 -> bits 31,21,1,0
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [IDX_W-1:0] i,
                                                  input logic [31:0] l);
        logic [31:0]       i32;
        logic [DATA_W-1:0] p;
        i32 = 32'(i);
        case (m)
            2'd0:    p = i32[DATA_W-1:0];
            2'd1:    p = l[DATA_W-1:0];
            2'd2:    p = DATA_W'(1) << (i32 % 32'(DATA_W));
            default: p = i32[0] ? {DATA_W/2{2'b10}} : {DATA_W/2{2'b01}};
        endcase
        return p;
    endfunction

    always_comb begin
        wr_req    = (state == S_WRITE);
        // A response arriving this cycle frees a slot, so a full pipeline may still issue.
        rd_req    = (state == S_READ) && ((outstanding != MAX_O) || avalon_sdram_readdatavalid);
        wr_acc    = wr_req && !avalon_sdram_waitrequest;
        rd_acc    = rd_req && !avalon_sdram_waitrequest;
        rsp_valid = avalon_sdram_readdatavalid && ((state == S_READ) || (state == S_DRAIN));
        last_iss  = (iss_idx == LAST_IDX);
        start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
        out_nxt   = outstanding + 4'(rd_acc) - 4'(rsp_valid);
        expected  = pattern(mode_q, chk_idx, chk_lfsr);
        mismatch  = rsp_valid && (avalon_sdram_readdata != expected);

        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_WRITE;
            S_WRITE: if (wr_acc && last_iss) state_nxt = S_READ;
            S_READ:  if (rd_acc && last_iss) state_nxt = S_DRAIN;
            // Leave on the edge that retires the final response so done follows it by one cycle.
            S_DRAIN: if (out_nxt == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = start_ok ? S_WRITE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= 2'd0;
            iss_idx     <= '0;
            chk_idx     <= '0;
            iss_lfsr    <= SEED;
            chk_lfsr    <= SEED;
            outstanding <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= '0;
            fe_addr_q   <= '0;
            fe_data_q   <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (start_ok) begin
                mode_q      <= mode;
                iss_idx     <= '0;
                chk_idx     <= '0;
                iss_lfsr    <= SEED;
                chk_lfsr    <= SEED;
                outstanding <= 4'd0;
                done_q      <= 1'b0;
                err_q       <= '0;
                fe_addr_q   <= '0;
                fe_data_q   <= '0;
            end else begin
                if (wr_acc) begin
                    if (last_iss) begin
                        // Read phase replays the sequence from the start.
                        iss_idx  <= '0;
                        iss_lfsr <= SEED;
                    end else begin
                        iss_idx  <= iss_idx + IDX_W'(1);
                        iss_lfsr <= lfsr_next(iss_lfsr);
                    end
                end
                if (rd_acc) begin
                    iss_idx  <= iss_idx + IDX_W'(1);
                    iss_lfsr <= lfsr_next(iss_lfsr);
                end
                if (rsp_valid) begin
                    chk_idx  <= chk_idx + IDX_W'(1);
                    chk_lfsr <= lfsr_next(chk_lfsr);
                end
                if (mismatch) begin
                    if (err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
                    if (err_q == '0) begin
                        fe_addr_q <= ADDR_W'(BASE_ADDR) + chk_idx[ADDR_W-1:0];
                        fe_data_q <= avalon_sdram_readdata;
                    end
                end
                if ((state_nxt == S_DONE) && (state != S_DONE)) done_q <= 1'b1;
            end
        end
    end

    assign busy           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign done           = done_q;
    assign pass           = done_q && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_data = fe_data_q;

    assign avalon_sdram_address      = (wr_req || rd_req) ? ADDR_W'(BASE_ADDR) + iss_idx[ADDR_W-1:0] : '0;
    assign avalon_sdram_writedata    = wr_req ? pattern(mode_q, iss_idx, iss_lfsr) : '0;
    assign avalon_sdram_byteenable_n = '0;
    assign avalon_sdram_chipselect   = wr_req || rd_req;
    assign avalon_sdram_read_n       = !rd_req;
    assign avalon_sdram_write_n      = !wr_req;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - scoreboard bench for sdram_pattern_tester
module tb_sdram_pattern_tester;
    localparam int TW = 16, MAXO = 4;
    localparam logic [31:0] SEED = 32'hACE1;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // DUT A: 16-word window at address 0
    logic start_a = 1'b0; logic [1:0] mode_a = 2'd0;
    logic busy_a, done_a, pass_a; logic [15:0] err_a; logic [7:0] fea_a; logic [15:0] fed_a;
    logic [7:0] addr_a; logic [1:0] ben_a; logic cs_a, rn_a, wn_a; logic [15:0] wd_a;
    logic [15:0] rd_a = '0; logic rdv_a = 1'b0, wait_a = 1'b0;

    // DUT B: single word at the top of the address space
    logic start_b = 1'b0; logic [1:0] mode_b = 2'd0;
    logic busy_b, done_b, pass_b; logic [15:0] err_b; logic [7:0] fea_b; logic [15:0] fed_b;
    logic [7:0] addr_b; logic [1:0] ben_b; logic cs_b, rn_b, wn_b; logic [15:0] wd_b;
    logic [15:0] rd_b = '0; logic rdv_b = 1'b0; logic wait_b = 1'b0;

    sdram_pattern_tester #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(0), .TEST_WORDS(TW),
        .MAX_OUTSTANDING(MAXO), .ERR_CNT_W(16), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_addr(fea_a), .first_err_data(fed_a),
        .avalon_sdram_address(addr_a), .avalon_sdram_byteenable_n(ben_a),
        .avalon_sdram_chipselect(cs_a), .avalon_sdram_writedata(wd_a),
        .avalon_sdram_read_n(rn_a), .avalon_sdram_write_n(wn_a),
        .avalon_sdram_readdata(rd_a), .avalon_sdram_readdatavalid(rdv_a),
        .avalon_sdram_waitrequest(wait_a));

    sdram_pattern_tester #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(255), .TEST_WORDS(1),
        .MAX_OUTSTANDING(MAXO), .ERR_CNT_W(16), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_addr(fea_b), .first_err_data(fed_b),
        .avalon_sdram_address(addr_b), .avalon_sdram_byteenable_n(ben_b),
        .avalon_sdram_chipselect(cs_b), .avalon_sdram_writedata(wd_b),
        .avalon_sdram_read_n(rn_b), .avalon_sdram_write_n(wn_b),
        .avalon_sdram_readdata(rd_b), .avalon_sdram_readdatavalid(rdv_b),
        .avalon_sdram_waitrequest(wait_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [15:0] pat(input int m, input int i, input logic [31:0] l);
        case (m)
            0:       return 16'(i);
            1:       return l[15:0];
            2:       return 16'h0001 << (i % 16);
            default: return ((i % 2) == 1) ? 16'hAAAA : 16'h5555;
        endcase
    endfunction

    // Slave model and scoreboard state for DUT A
    typedef struct { logic [15:0] data; int due; } rsp_t;
    typedef struct { logic [7:0] addr; logic [15:0] data; } wexp_t;
    typedef struct { logic [15:0] err; logic [7:0] fa; logic [15:0] fd; logic pass; } sexp_t;
    logic [15:0] mem [0:255];
    rsp_t  rq[$];
    wexp_t wq[$];
    sexp_t sq[$];
    int  lat = 2, corrupt_addr = -1, cyc = 0, n_wr = 0, n_rd = 0, out_m = 0, max_out = 0;
    int  last_rdv_cyc = -10;
    bit  rand_wait = 1'b0, mon_en = 1'b0, stalled_prev = 1'b0, done_prev = 1'b0;
    logic [7:0] p_addr; logic [15:0] p_wd; logic p_rn, p_wn;

    always begin
        @(negedge clk);
        cyc++;
        wait_a = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            rdv_a = 1'b1; rd_a = rq[0].data; rq.delete(0);
        end else begin
            rdv_a = 1'b0; rd_a = 16'h0000;
        end
        #1;
        if (mon_en) begin
            if (stalled_prev)
                check("stall_hold", {addr_a, wd_a, rn_a, wn_a}, {p_addr, p_wd, p_rn, p_wn});
            check("chipselect", cs_a, !rn_a || !wn_a);
            if (!rn_a) check("throttle", (out_m < MAXO) || rdv_a, 1);
            if (!wn_a && !wait_a) begin
                wexp_t e;
                n_wr++;
                mem[addr_a] = wd_a;
                check("byteenable_n", ben_a, 0);
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("wr_addr", addr_a, e.addr);
                    check("wr_data", wd_a, e.data);
                end
            end
            if (!rn_a && !wait_a) begin
                n_rd++;
                rq.push_back('{data: mem[addr_a] ^ ((int'(addr_a) == corrupt_addr) ? 16'h0001 : 16'h0000),
                               due: cyc + lat});
                out_m++;
            end
            if (rdv_a) begin
                out_m--;
                last_rdv_cyc = cyc;
            end
            if (out_m > max_out) max_out = out_m;
            if (!rn_a && !wait_a) check("outstanding_max", out_m <= MAXO, 1);
            if (done_a && !done_prev) begin
                sexp_t s;
                if (sq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    s = sq.pop_front();
                    check("status_err_count", err_a, s.err);
                    check("status_first_err_addr", fea_a, s.fa);
                    check("status_first_err_data", fed_a, s.fd);
                    check("status_pass", pass_a, s.pass);
                    check("status_busy_low", busy_a, 0);
                    check("done_latency", cyc - last_rdv_cyc, 1);
                end
            end
            done_prev    = done_a;
            stalled_prev = (!rn_a || !wn_a) && wait_a;
            p_addr = addr_a; p_wd = wd_a; p_rn = rn_a; p_wn = wn_a;
        end
    end

    // Slave model for DUT B: zero wait, one-cycle read latency
    logic [15:0] mem_b = 16'h0000, pend_data_b = 16'h0000;
    bit pend_b = 1'b0;
    int nwr_b = 0, nrd_b = 0;
    always begin
        @(negedge clk);
        rdv_b = pend_b; rd_b = pend_data_b; pend_b = 1'b0;
        #1;
        if (mon_en) begin
            if (!wn_b) begin
                nwr_b++; mem_b = wd_b;
                check("b_wr_addr", addr_b, 8'hFF);
                check("b_wr_data", wd_b, 16'h0001);
            end
            if (!rn_b) begin
                nrd_b++; pend_b = 1'b1; pend_data_b = mem_b;
                check("b_rd_addr", addr_b, 8'hFF);
            end
        end
    end

    task automatic launch(input logic [1:0] m);
        logic [31:0] l;
        logic [15:0] hand [0:2];
        logic [15:0] d;
        hand[0] = 16'hACE1; hand[1] = 16'h59C3; hand[2] = 16'hB386;
        l = SEED;
        for (int i = 0; i < TW; i++) begin
            d = pat(int'(m), i, l);
            if (m == 2'd1 && i < 3) d = hand[i];
            wq.push_back('{addr: 8'(i), data: d});
            l = lfsr_step(l);
        end
        @(posedge clk); #2 mode_a = m; start_a = 1'b1;
        @(posedge clk); #2 start_a = 1'b0; mode_a = 2'd0;
        @(negedge clk); #2;
        check("first_write_presented", wn_a, 0);
        check("busy_after_start", busy_a, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check({name, "_done_timeout"}, n < 3000, 1);
        @(negedge clk); #2;
    endtask

    task automatic run_a(input string name, input logic [1:0] m, input int l, input bit rw,
                         input int corr, input logic [15:0] e_err, input logic [7:0] e_fa,
                         input logic [15:0] e_fd, input logic e_pass, input bit poke);
        int bw, br;
        lat = l; rand_wait = rw; corrupt_addr = corr;
        bw = n_wr; br = n_rd;
        sq.push_back('{err: e_err, fa: e_fa, fd: e_fd, pass: e_pass});
        launch(m);
        if (poke) begin
            repeat (3) @(negedge clk);
            #2 mode_a = 2'd3; start_a = 1'b1;
            @(posedge clk); #2 start_a = 1'b0; mode_a = 2'd0;
            @(negedge clk); #2;
            check({name, "_busy_after_ignored_start"}, busy_a, 1);
            check({name, "_done_after_ignored_start"}, done_a, 0);
        end
        wait_done(name);
        check({name, "_writes"}, n_wr - bw, TW);
        check({name, "_reads"}, n_rd - br, TW);
        check({name, "_wq_empty"}, wq.size(), 0);
        check({name, "_sq_empty"}, sq.size(), 0);
        rand_wait = 1'b0; corrupt_addr = -1;
    endtask

    initial begin
        int n, br;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        check("rst_busy", busy_a, 0);      check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);      check("rst_err", err_a, 0);
        check("rst_fea", fea_a, 0);        check("rst_fed", fed_a, 0);
        check("rst_read_n", rn_a, 1);      check("rst_write_n", wn_a, 1);
        check("rst_cs", cs_a, 0);          check("rst_addr", addr_a, 0);
        check("rst_wdata", wd_a, 0);       check("rst_b_busy", busy_b, 0);
        mon_en = 1'b1;

        run_a("t1_mode0",     2'd0, 2, 1'b0, -1, 16'd0, 8'd0, 16'h0000, 1'b1, 1'b0);
        run_a("t2_randwait",  2'd0, 2, 1'b1, -1, 16'd0, 8'd0, 16'h0000, 1'b1, 1'b0);
        run_a("t3_mode3_err", 2'd3, 2, 1'b0,  5, 16'd1, 8'd5, 16'hAAAB, 1'b0, 1'b0);
        max_out = 0;
        run_a("t4_lfsr_lat6", 2'd1, 6, 1'b0, -1, 16'd0, 8'd0, 16'h0000, 1'b1, 1'b0);
        check("t4_max_outstanding", max_out, MAXO);
        run_a("t6_busy_start", 2'd0, 2, 1'b0, -1, 16'd0, 8'd0, 16'h0000, 1'b1, 1'b1);

        // Reset in the middle of the read phase
        lat = 6;
        br = n_rd;
        launch(2'd2);
        n = 0;
        while (n_rd - br < 6 && n < 500) begin @(negedge clk); n++; end
        check("t5_reached_read", n < 500, 1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("t5_read_n", rn_a, 1);  check("t5_write_n", wn_a, 1);
        check("t5_cs", cs_a, 0);      check("t5_busy", busy_a, 0);
        repeat (20) @(negedge clk);
        #2;
        check("t5_late_rdv_err", err_a, 0);
        check("t5_late_rdv_done", done_a, 0);
        check("t5_model_drained", out_m, 0);
        check("t5_wq_empty", wq.size(), 0);
        run_a("t5_restart", 2'd0, 2, 1'b0, -1, 16'd0, 8'd0, 16'h0000, 1'b1, 1'b0);

        // Single-word window
        @(posedge clk); #2 mode_b = 2'd2; start_b = 1'b1;
        @(posedge clk); #2 start_b = 1'b0; mode_b = 2'd0;
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("t6b_done_timeout", n < 200, 1);
        #2;
        check("t6b_writes", nwr_b, 1);
        check("t6b_reads", nrd_b, 1);
        check("t6b_pass", pass_b, 1);
        check("t6b_err", err_b, 0);
        check("t6b_busy", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
